chunk_mem_ctrl: RTL and testbench

CHUNK_MEM_CTRL -- requirements
Module: chunk_mem_ctrl

---
 rtl/chunk_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_chunk_mem_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chunk_mem_ctrl.sv
// ---------------------------------------------------------------------------
// chunk_mem_ctrl
//   Chunked write / word read controller around a single-port-write,
//   registered-read memory that maps onto synchronous block RAM.
//   Words are assembled from NCHUNK narrow chunks (slice 0 = LSBs) and
//   committed to mem[wr_addr] when the last chunk arrives. Reads return a
//   full word one cycle after the command; READ_NEXT streams from an
//   internal read pointer.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset (memory not cleared)
//   cmd_valid  in   command strobe
//   cmd_op     in   00 SET_WADDR, 01 WR_CHUNK, 10 READ, 11 READ_NEXT
//   cmd_data   in   address (SET_WADDR/READ) or chunk in low CHUNK_W bits
//   rd_data    out  registered read data, 0 when no read was accepted
//   rd_valid   out  rd_data holds a read result
//   wr_done    out  one-cycle pulse after a word commit
//   wr_addr    out  current write pointer
//   chunk_cnt  out  chunks staged toward the current word
// ---------------------------------------------------------------------------
module chunk_mem_ctrl #(
  parameter  int ADDR_W  = 10,
  parameter  int DATA_W  = 12,
  parameter  int CHUNK_W = 6,
  localparam int NCHUNK  = DATA_W / CHUNK_W,
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CNT_W-1:0]  chunk_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  // Staging only needs the slices below the final chunk; the final chunk is
  // taken straight from cmd_data on the committing edge.
  localparam int SW    = (NCHUNK > 1) ? (NCHUNK - 1) * CHUNK_W : 1;

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WR_CHUNK  = 2'b01,
    OP_READ      = 2'b10,
    OP_READ_NEXT = 2'b11
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]  chunk_cnt_q, chunk_cnt_d;
  logic [SW-1:0]     stage_q,     stage_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              wr_done_q;

  logic              mem_we;
  logic [DATA_W-1:0] commit_word;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CHUNK_W-1:0] chunk;
  logic              last_chunk;

  assign chunk      = cmd_data[CHUNK_W-1:0];
  assign last_chunk = (chunk_cnt_q == CNT_W'(NCHUNK - 1));

  always_comb begin
    wr_addr_d   = wr_addr_q;
    rd_ptr_d    = rd_ptr_q;
    chunk_cnt_d = chunk_cnt_q;
    stage_d     = stage_q;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q;

    commit_word = '0;
    for (int i = 0; i < NCHUNK - 1; i++) begin
      commit_word[i*CHUNK_W +: CHUNK_W] = stage_q[i*CHUNK_W +: CHUNK_W];
    end
    commit_word[(NCHUNK-1)*CHUNK_W +: CHUNK_W] = chunk;

    if (cmd_valid) begin
      case (op_e'(cmd_op))
        OP_SET_WADDR: begin
          // Any partially assembled word is dropped here.
          wr_addr_d   = cmd_data;
          chunk_cnt_d = '0;
          stage_d     = '0;
        end
        OP_WR_CHUNK: begin
          if (last_chunk) begin
            mem_we      = 1'b1;
            chunk_cnt_d = '0;
            stage_d     = '0;
            wr_addr_d   = wr_addr_q + ADDR_W'(1);
          end else begin
            for (int i = 0; i < NCHUNK - 1; i++) begin
              if (chunk_cnt_q == CNT_W'(i)) begin
                stage_d[i*CHUNK_W +: CHUNK_W] = chunk;
              end
            end
            chunk_cnt_d = chunk_cnt_q + CNT_W'(1);
          end
        end
        OP_READ: begin
          rd_en    = 1'b1;
          rd_addr  = cmd_data;
          rd_ptr_d = cmd_data + ADDR_W'(1);
        end
        OP_READ_NEXT: begin
          rd_en    = 1'b1;
          rd_addr  = rd_ptr_q;
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q   <= '0;
      rd_ptr_q    <= '0;
      chunk_cnt_q <= '0;
      stage_q     <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      chunk_cnt_q <= chunk_cnt_d;
      stage_q     <= stage_d;
      wr_done_q   <= mem_we;
    end
  end

  // Memory array has no reset so it infers as block RAM; reset still has to
  // block a commit that coincides with it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wr_addr_q] <= commit_word;
    end
  end

  // Registered read port; the output register is zeroed whenever no read
  // was accepted so downstream logic can OR-combine without gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      rd_data_q  <= mem[rd_addr];
      rd_valid_q <= 1'b1;
    end else begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_done   = wr_done_q;
  assign wr_addr   = wr_addr_q;
  assign chunk_cnt = chunk_cnt_q;

endmodule

// File: tb/tb_chunk_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chunk_mem_ctrl
//   Drives one command stream into two instances (default geometry and a
//   16-bit / 4-bit-chunk / 64-deep geometry) and compares every output of
//   both against a word-level reference model after each clock edge.
// ---------------------------------------------------------------------------
module tb_chunk_mem_ctrl;

  localparam int A0 = 10, D0 = 12, C0 = 6;
  localparam int A1 = 6,  D1 = 16, C1 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_data;

  logic [D0-1:0] rd_data0;
  logic          rd_valid0, wr_done0;
  logic [A0-1:0] wr_addr0;
  logic [0:0]    chunk_cnt0;

  logic [D1-1:0] rd_data1;
  logic          rd_valid1, wr_done1;
  logic [A1-1:0] wr_addr1;
  logic [1:0]    chunk_cnt1;

  always #5 clk = ~clk;

  chunk_mem_ctrl u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .wr_done(wr_done0),
    .wr_addr(wr_addr0), .chunk_cnt(chunk_cnt0)
  );

  chunk_mem_ctrl #(.ADDR_W(A1), .DATA_W(D1), .CHUNK_W(C1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data[A1-1:0]),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .wr_done(wr_done1),
    .wr_addr(wr_addr1), .chunk_cnt(chunk_cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, one slot per instance.
  int m_mem [2][1024];
  int m_wptr[2], m_rptr[2], m_n[2], m_sv[2];
  int e_rd[2], e_rv[2], e_wd[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Word-level behaviour: chunks accumulate arithmetically until NCHUNK
  // have arrived, then the whole word lands in the array.
  task automatic model_step(input int k, input bit r, input bit v, input int op, input int d);
    int aw, dw, cw, nch, am, cm, a;
    aw  = (k == 0) ? A0 : A1;
    dw  = (k == 0) ? D0 : D1;
    cw  = (k == 0) ? C0 : C1;
    nch = dw / cw;
    am  = (1 << aw) - 1;
    cm  = (1 << cw) - 1;
    e_rd[k] = 0; e_rv[k] = 0; e_wd[k] = 0;
    if (r) begin
      m_wptr[k] = 0; m_rptr[k] = 0; m_n[k] = 0; m_sv[k] = 0;
    end else if (v) begin
      case (op)
        0: begin
          m_wptr[k] = d & am; m_n[k] = 0; m_sv[k] = 0;
        end
        1: begin
          m_sv[k] = m_sv[k] + ((d & cm) << (m_n[k] * cw));
          m_n[k]++;
          if (m_n[k] == nch) begin
            m_mem[k][m_wptr[k]] = m_sv[k];
            m_wptr[k] = (m_wptr[k] + 1) & am;
            m_n[k] = 0; m_sv[k] = 0; e_wd[k] = 1;
          end
        end
        2: begin
          a = d & am;
          e_rd[k] = m_mem[k][a]; e_rv[k] = 1;
          m_rptr[k] = (a + 1) & am;
        end
        default: begin
          e_rd[k] = m_mem[k][m_rptr[k]]; e_rv[k] = 1;
          m_rptr[k] = (m_rptr[k] + 1) & am;
        end
      endcase
    end
  endtask

  task automatic check_all();
    chk("i0.rd_data",   rd_data0,   e_rd[0]);
    chk("i0.rd_valid",  rd_valid0,  e_rv[0]);
    chk("i0.wr_done",   wr_done0,   e_wd[0]);
    chk("i0.wr_addr",   wr_addr0,   m_wptr[0]);
    chk("i0.chunk_cnt", chunk_cnt0, m_n[0]);
    chk("i1.rd_data",   rd_data1,   e_rd[1]);
    chk("i1.rd_valid",  rd_valid1,  e_rv[1]);
    chk("i1.wr_done",   wr_done1,   e_wd[1]);
    chk("i1.wr_addr",   wr_addr1,   m_wptr[1]);
    chk("i1.chunk_cnt", chunk_cnt1, m_n[1]);
  endtask

  // Inputs change #1 after the edge; outputs are sampled #1 after the next.
  task automatic cycle(input bit r, input bit v, input int op, input int d);
    rst       = r;
    cmd_valid = v;
    cmd_op    = 2'(op);
    cmd_data  = 10'(d);
    @(posedge clk);
    model_step(0, r, v, op, d);
    model_step(1, r, v, op, d);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    #1;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 10'h3FF);

    // Fill both arrays with known random words so every read is defined.
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 2048; i++) cycle(0, 1, 1, int'($urandom_range(1023)));

    // Basic two-chunk word.
    cycle(0, 1, 0, 10'h005);
    cycle(0, 1, 1, 10'h02A);
    cycle(0, 1, 1, 10'h015);
    chk("r28.wr_done", wr_done0, 1);
    chk("r28.wr_addr", wr_addr0, 10'h006);
    cycle(0, 1, 2, 10'h005);
    chk("r28.rd_valid", rd_valid0, 1);
    chk("r28.rd_data",  rd_data0, 12'h56A);
    cycle(0, 0, 0, 0);

    // Write pointer wrap, then back-to-back READ / READ_NEXT across it.
    cycle(0, 1, 0, 10'h3FF);
    cycle(0, 1, 1, 10'h011);
    cycle(0, 1, 1, 10'h022);
    cycle(0, 1, 1, 10'h033);
    cycle(0, 1, 1, 10'h004);
    chk("r29.wr_addr0", wr_addr0, 10'h001);
    chk("r29.wr_addr1", wr_addr1, 6'h00);
    cycle(0, 1, 2, 10'h3FF);
    chk("r29.word0", rd_data0, 12'h891);
    chk("r29.word1x", rd_data1, 16'h4321);
    cycle(0, 1, 3, 0);
    chk("r29.word0n", rd_data0, 12'h133);

    // Partial word abandoned by SET_WADDR.
    cycle(0, 1, 0, 10'h010);
    cycle(0, 1, 1, 10'h001);
    cycle(0, 1, 0, 10'h020);
    chk("r30.chunk_cnt", chunk_cnt0, 0);
    cycle(0, 1, 2, 10'h010);

    // Reset mid-assembly with a concurrent WR_CHUNK.
    cycle(0, 1, 0, 10'h040);
    cycle(0, 1, 1, 10'h005);
    cycle(1, 1, 1, 10'h007);
    chk("r31.wr_addr", wr_addr0, 0);
    cycle(0, 1, 1, 10'h009);
    cycle(0, 1, 1, 10'h00A);
    cycle(0, 1, 2, 10'h000);
    cycle(0, 1, 2, 10'h3FF);

    // Idle cycle between reads leaves rd_ptr alone.
    cycle(0, 1, 2, 10'h100);
    cycle(0, 0, 3, 10'h2AA);
    chk("r32.rd_valid", rd_valid0, 0);
    cycle(0, 1, 3, 0);

    // Random traffic including idle garbage and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(63) == 0, $urandom_range(3) != 0,
            int'($urandom_range(3)), int'($urandom_range(1023)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
